// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder: one full-adder bit per cycle, WIDTH-cycle latency
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_add_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_q;
  logic             out_carry_q;
  logic [CW-1:0]    cnt_q;

  logic in_ready;
  logic out_valid;
  logic busy;
  logic accept;
  logic run;

  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

  half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s), .b(carry_q), .s(ha1_s), .c(ha1_c));
  assign fa_c = ha0_c | ha1_c;

  // Each new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at res_q[0].
  assign res_nxt = (res_q >> 1) | (WIDTH'(ha1_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        run       = 1'b1;
        state_nxt = (cnt_q == LAST) ? DONE : RUN;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_nxt = bus.out_ready ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_carry_q mirrors carry_q only on RUN edges so the visible carry never moves at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      out_carry_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (run) begin
      a_q         <= a_q >> 1;
      b_q         <= b_q >> 1;
      res_q       <= res_nxt;
      carry_q     <= fa_c;
      out_carry_q <= fa_c;
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_sum   = res_q;
  assign bus.out_carry = out_carry_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - scoreboard bench for the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_serial_add_sequencer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_add_sequencer_if #(.WIDTH(8)) bus8 ();
  serial_add_sequencer_if #(.WIDTH(1)) bus1 ();

  serial_add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check("idle_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.in_a     = a;
    bus8.in_b     = b;
    @(posedge clk);
    q8.push_back({1'b0, a} + {1'b0, b});
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_a     = 8'($urandom);
    bus8.in_b     = 8'($urandom);
  endtask

  // Counts edges from accept to out_valid while scribbling on the ignored inputs.
  task automatic wait8();
    int   cyc  = 0;
    logic seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus8.out_valid) begin
        seen = 1'b1;
      end else begin
        check("run_busy", 32'(bus8.busy), 32'd1);
        check("run_ready", 32'(bus8.in_ready), 32'd0);
        bus8.in_valid = 1'($urandom);
        bus8.in_a     = 8'($urandom);
        bus8.in_b     = 8'($urandom);
      end
    end
    bus8.in_valid = 1'b0;
    check("latency8", 32'(cyc), 32'd8);
  endtask

  task automatic take8(input int hold);
    logic [8:0] exp;
    check("sb_nonempty", 32'(q8.size() > 0), 32'd1);
    exp = (q8.size() > 0) ? q8.pop_front() : 9'h1ff;
    check("sum8", 32'(bus8.out_sum), 32'(exp[7:0]));
    check("carry8", 32'(bus8.out_carry), 32'(exp[8]));
    for (int i = 0; i < hold; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_a     = 8'($urandom);
      bus8.in_b     = 8'($urandom);
      @(posedge clk);
      #1;
      check("bp_valid", 32'(bus8.out_valid), 32'd1);
      check("bp_ready", 32'(bus8.in_ready), 32'd0);
      check("bp_sum", 32'(bus8.out_sum), 32'(exp[7:0]));
      check("bp_carry", 32'(bus8.out_carry), 32'(exp[8]));
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    check("hs_valid", 32'(bus8.out_valid), 32'd0);
    check("hs_busy", 32'(bus8.busy), 32'd0);
    check("hs_ready", 32'(bus8.in_ready), 32'd1);
    check("hs_keep_sum", 32'(bus8.out_sum), 32'(exp[7:0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus8.in_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus8.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus8.out_sum), 32'd0);
    check({tag, "_carry"}, 32'(bus8.out_carry), 32'd0);
  endtask

  initial begin
    logic a1, b1;
    logic [1:0] e1;
    int cyc;

    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.out_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    accept8(8'hFF, 8'h01); wait8(); take8(0);
    accept8(8'hA5, 8'h5A); wait8(); take8(0);
    accept8(8'h80, 8'h80); wait8(); take8(0);
    accept8(8'h12, 8'h34); wait8(); take8(5);
    accept8(8'hC3, 8'h3C); wait8(); take8(0);

    // Reset asserted mid-cycle while a result is waiting in DONE.
    accept8(8'hA5, 8'h5A); wait8();
    #3;
    rst_n = 1'b0;
    void'(q8.pop_front());
    #1;
    check_reset_outputs("rst_done");
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort three edges into RUN.
    accept8(8'h33, 8'h11);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(q8.pop_front());
    #1;
    check_reset_outputs("rst_run");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_valid", 32'(bus8.out_valid), 32'd0);
      check("abort_busy", 32'(bus8.busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept8(8'h0F, 8'h01); wait8(); take8(0);

    for (int i = 0; i < 4; i++) begin
      accept8(8'($urandom), 8'($urandom)); wait8(); take8(i % 2);
    end

    for (int i = 0; i < 4; i++) begin
      a1 = (i >> 1) & 1;
      b1 = i & 1;
      @(negedge clk);
      check("w1_ready", 32'(bus1.in_ready), 32'd1);
      bus1.in_valid = 1'b1;
      bus1.in_a     = a1;
      bus1.in_b     = b1;
      @(posedge clk);
      q1.push_back({a1 & b1, a1 ^ b1});
      #1;
      bus1.in_valid = 1'b0;
      bus1.in_a     = ~a1;
      bus1.in_b     = ~b1;
      cyc = 0;
      while (!bus1.out_valid && cyc < 10) begin
        @(posedge clk);
        cyc++;
        #1;
      end
      check("latency1", 32'(cyc), 32'd1);
      e1 = q1.pop_front();
      check("w1_sum", 32'(bus1.out_sum), 32'(e1[0]));
      check("w1_carry", 32'(bus1.out_carry), 32'(e1[1]));
      bus1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus1.out_ready = 1'b0;
      check("w1_hs_valid", 32'(bus1.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit width; legal range 1..32.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  operand pair presented.
REQ-005 The block SHALL have port in_ready  output  1  sequencer can accept an operand pair.
REQ-006 The block SHALL have port in_a  input  WIDTH  operand A.
REQ-007 The block SHALL have port in_b  input  WIDTH  operand B.
REQ-008 The block SHALL have port out_valid  output  1  result available.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port out_sum  output  WIDTH  sum bits A+B, modulo 2^WIDTH.
REQ-011 The block SHALL have port out_carry  output  1  carry out of bit WIDTH-1.
REQ-012 The block SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 The datapath SHALL be one 1-bit full adder built from two half_adder instances plus an OR of their carries; the block SHALL add only through it, one bit per cycle.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; any unused encoding SHALL go to IDLE on the next edge.
REQ-015 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-016 IDLE->RUN on an edge with in_valid=1 and in_ready=1: load shift regs A<=in_a, B<=in_b, carry reg<=0, bit counter<=0.
REQ-017 Each RUN edge: full-adder inputs = A[0], B[0], carry reg; sum bit shifts into result MSB (result shifts right); carry reg<=carry out; A, B shift right; counter increments.
REQ-018 RUN->DONE on the edge where counter reaches WIDTH-1, i.e. exactly WIDTH RUN edges after the accept edge.
REQ-019 In DONE: out_valid=1, in_ready=0, out_sum=result reg, out_carry=carry reg.
REQ-020 out_valid SHALL first be high WIDTH cycles after the accept edge, so latency = WIDTH cycles; one operation in flight at most.
REQ-021 DONE->IDLE on an edge with out_ready=1; with out_ready=0, out_valid, out_sum and out_carry SHALL hold stable indefinitely.
REQ-022 in_valid, in_a and in_b SHALL be ignored in RUN and DONE; operand changes after acceptance SHALL not affect the result.
REQ-023 A new accept SHALL occur no earlier than the cycle after the output handshake (IDLE entered); no same-cycle output and input handshake.
REQ-024 out_sum and out_carry SHALL keep the last result in IDLE and change only during RUN; consumers qualify them with out_valid.
REQ-025 WIDTH=1: RUN lasts exactly one edge; out_sum=a^b, out_carry=a&b.
REQ-026 The counter SHALL be wide enough to hold WIDTH-1; no wrap occurs within an operation.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_carry=0, A=B=0, counter=0.
REQ-028 Reset in RUN or DONE SHALL abort the operation without producing any output handshake; state holds IDLE while rst_n=0.
REQ-029 After rst_n deasserts, the first accept edge SHALL be the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-030 Bench SHALL cover reset: assert rst_n=0 mid-cycle -> in_ready=1, out_valid=0, busy=0, out_sum=0, out_carry=0 before the next clk edge.
REQ-031 Bench SHALL cover overflow: WIDTH=8, in_a=8'hFF, in_b=8'h01 -> out_valid exactly 8 cycles after accept, out_sum=8'h00, out_carry=1.
REQ-032 Bench SHALL cover no-carry: in_a=8'hA5, in_b=8'h5A -> out_sum=8'hFF, out_carry=0; then in_a=8'h80, in_b=8'h80 -> out_sum=8'h00, out_carry=1.
REQ-033 Bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and the result hold; in_valid=1 with new operands meanwhile is not accepted.
REQ-034 Bench SHALL cover abort: rst_n pulsed low 3 cycles into RUN -> IDLE, no out_valid; next op 8'h0F+8'h01 -> out_sum=8'h10, out_carry=0.
REQ-035 Bench SHALL cover WIDTH=1: all four a/b combinations -> sum and carry match the half-add truth table after 1 cycle of latency each.
